// File: rtl/mpsoc_axi4lite_ahb3_pkg.sv
// Shared encodings for the AXI4-Lite to AHB3-Lite bridge: AHB transfer
// types, burst and size codes, AXI response codes and the bridge FSM states.
package mpsoc_axi4lite_ahb3_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        R_ADDR,
        R_DATA,
        R_RESP
    } state_t;

endpackage

// File: rtl/mpsoc_axi4lite_strb_decode.sv
// Maps an AXI write strobe onto a single AHB transfer. A strobe is usable
// only when its set bits are contiguous, their count is a power of two and
// the run starts on a multiple of that count; anything else is illegal.
module mpsoc_axi4lite_strb_decode
    import mpsoc_axi4lite_ahb3_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN/8-1:0]         strb,
    output logic                      legal,
    output logic [2:0]                size,
    output logic [$clog2(XLEN/8)-1:0] offset
);

    localparam int NB     = XLEN / 8;
    localparam int NB_LOG = $clog2(NB);

    typedef logic [NB-1:0]     strb_t;
    typedef logic [NB_LOG-1:0] off_t;

    // Compare the strobe against every naturally aligned power-of-two mask
    always_comb begin
        legal  = 1'b0;
        size   = HSIZE_BYTE;
        offset = '0;
        for (int s = 0; s <= NB_LOG; s++) begin
            for (int o = 0; o < NB; o++) begin
                if (((o % (1 << s)) == 0) &&
                    (strb == strb_t'(((1 << (1 << s)) - 1) << o))) begin
                    legal  = 1'b1;
                    size   = 3'(s);
                    offset = off_t'(o);
                end
            end
        end
    end

endmodule

// File: rtl/mpsoc_axi4lite2ahb3_bridge.sv
// AXI4-Lite slave to AHB3-Lite master bridge. Each AXI read or write becomes
// one AHB SINGLE transfer; one transaction is in flight at a time and
// simultaneous read/write requests are granted alternately.
module mpsoc_axi4lite2ahb3_bridge
    import mpsoc_axi4lite_ahb3_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic [PLEN-1:0]   AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              AWVALID,
    output logic              AWREADY,

    input  logic [XLEN-1:0]   WDATA,
    input  logic [XLEN/8-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,

    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,

    input  logic [PLEN-1:0]   ARADDR,
    input  logic [2:0]        ARPROT,
    input  logic              ARVALID,
    output logic              ARREADY,

    output logic [XLEN-1:0]   RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,

    output logic              HSEL,
    output logic [PLEN-1:0]   HADDR,
    output logic [XLEN-1:0]   HWDATA,
    input  logic [XLEN-1:0]   HRDATA,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic [1:0]        HTRANS,
    output logic              HMASTLOCK,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam int NB_LOG = $clog2(XLEN / 8);

    state_t              state;
    state_t              state_nxt;
    logic                last_wr;
    logic                wr_pend;
    logic                rd_pend;
    logic                grant_wr;
    logic                grant_rd;
    logic                strb_legal;
    logic [2:0]          strb_size;
    logic [NB_LOG-1:0]   strb_off;
    logic                unused_bits;

    mpsoc_axi4lite_strb_decode #(
        .XLEN (XLEN)
    ) u_strb_decode (
        .strb   (WSTRB),
        .legal  (strb_legal),
        .size   (strb_size),
        .offset (strb_off)
    );

    // A write needs both address and data; ties go to the side not served last
    assign wr_pend  = AWVALID & WVALID;
    assign rd_pend  = ARVALID;
    assign grant_wr = wr_pend & (~rd_pend | ~last_wr);
    assign grant_rd = rd_pend & (~wr_pend | last_wr);

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;

    // Sub-word address bits and the instruction/data-agnostic PROT bit are not forwarded
    assign unused_bits = ^{AWADDR[NB_LOG-1:0], ARADDR[NB_LOG-1:0], AWPROT[1], ARPROT[1]};

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state plus handshake and AHB control outputs decoded from the state
    always_comb begin
        state_nxt = state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        ARREADY   = 1'b0;
        BVALID    = 1'b0;
        RVALID    = 1'b0;
        HSEL      = 1'b0;
        HTRANS    = HTRANS_IDLE;
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    AWREADY   = 1'b1;
                    WREADY    = 1'b1;
                    state_nxt = strb_legal ? W_ADDR : W_RESP;
                end else if (grant_rd) begin
                    ARREADY   = 1'b1;
                    state_nxt = R_ADDR;
                end
            end
            W_ADDR: begin
                HSEL   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                if (HREADY) state_nxt = W_DATA;
            end
            W_DATA: begin
                if (HREADY) state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) state_nxt = IDLE;
            end
            R_ADDR: begin
                HSEL   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                if (HREADY) state_nxt = R_DATA;
            end
            R_DATA: begin
                if (HREADY) state_nxt = R_RESP;
            end
            R_RESP: begin
                RVALID = 1'b1;
                if (RREADY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted request and the AHB data-phase result
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR   <= '0;
            HWDATA  <= '0;
            HWRITE  <= 1'b0;
            HSIZE   <= HSIZE_BYTE;
            HPROT   <= 4'b0011;
            BRESP   <= RESP_OKAY;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
            last_wr <= 1'b0;
        end else begin
            if (AWREADY) begin
                last_wr <= 1'b1;
                BRESP   <= strb_legal ? RESP_OKAY : RESP_SLVERR;
                if (strb_legal) begin
                    HADDR  <= {AWADDR[PLEN-1:NB_LOG], strb_off};
                    HWDATA <= WDATA;
                    HWRITE <= 1'b1;
                    HSIZE  <= strb_size;
                    HPROT  <= {2'b00, AWPROT[0], ~AWPROT[2]};
                end
            end else if (ARREADY) begin
                last_wr <= 1'b0;
                HADDR   <= {ARADDR[PLEN-1:NB_LOG], {NB_LOG{1'b0}}};
                HWRITE  <= 1'b0;
                HSIZE   <= 3'(NB_LOG);
                HPROT   <= {2'b00, ARPROT[0], ~ARPROT[2]};
            end
            // HRESP only counts on the HREADY edge, which covers two-cycle error replies
            if (state == W_DATA && HREADY) begin
                BRESP <= HRESP ? RESP_SLVERR : RESP_OKAY;
            end
            if (state == R_DATA && HREADY) begin
                RDATA <= HRDATA;
                RRESP <= HRESP ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_axi4lite2ahb3_bridge.sv
// Directed bench for the AXI4-Lite to AHB3-Lite bridge with a response scoreboard.
module tb_mpsoc_axi4lite2ahb3_bridge;

    localparam int XLEN = 64;
    localparam int PLEN = 64;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [PLEN-1:0]   AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [XLEN-1:0]   WDATA;
    logic [XLEN/8-1:0] WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [PLEN-1:0]   ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [XLEN-1:0]   RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic              HSEL;
    logic [PLEN-1:0]   HADDR;
    logic [XLEN-1:0]   HWDATA;
    logic [XLEN-1:0]   HRDATA;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [1:0]        HTRANS;
    logic              HMASTLOCK;
    logic              HREADY;
    logic              HRESP;

    mpsoc_axi4lite2ahb3_bridge #(
        .XLEN (XLEN),
        .PLEN (PLEN)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .AWADDR    (AWADDR),
        .AWPROT    (AWPROT),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .ARADDR    (ARADDR),
        .ARPROT    (ARPROT),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Called in the first BVALID cycle; stalls BREADY, then completes the handshake
    task automatic collect_b(input int stall);
        exp_t e;
        e.resp = 2'bxx;
        e.data = '0;
        check("bvalid", BVALID, 1);
        check("sb_depth_b", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            BREADY = 1'b0;
            check("bresp_hold", BRESP, e.resp);
            tick();
            check("bvalid_hold", BVALID, 1);
        end
        BREADY = 1'b1;
        check("bresp", BRESP, e.resp);
        tick();
        BREADY = 1'b0;
        check("bvalid_drop", BVALID, 0);
    endtask

    // Called in the first RVALID cycle; stalls RREADY, then completes the handshake
    task automatic collect_r(input int stall);
        exp_t e;
        e.resp = 2'bxx;
        e.data = 'x;
        check("rvalid", RVALID, 1);
        check("sb_depth_r", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            RREADY = 1'b0;
            check("rdata_hold", RDATA, e.data);
            check("rresp_hold", RRESP, e.resp);
            tick();
            check("rvalid_hold", RVALID, 1);
        end
        RREADY = 1'b1;
        check("rdata", RDATA, e.data);
        check("rresp", RRESP, e.resp);
        tick();
        RREADY = 1'b0;
        check("rvalid_drop", RVALID, 0);
    endtask

    task automatic run_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input logic [2:0] prot, input logic legal, input logic [63:0] e_haddr,
                             input logic [2:0] e_hsize, input int waits, input logic err, input int bstall);
        exp_t e;
        AWADDR  = addr;
        AWPROT  = prot;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        #1;
        check("awready", AWREADY, 1);
        check("wready", WREADY, 1);
        check("arready_wgrant", ARREADY, 0);
        check("htrans_accept", HTRANS, 2'b00);
        e.resp = (legal && !err) ? 2'b00 : 2'b10;
        e.data = '0;
        sb.push_back(e);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (legal) begin
            check("w_htrans_addr", HTRANS, 2'b10);
            check("w_hsel_addr", HSEL, 1);
            check("w_haddr", HADDR, e_haddr);
            check("w_hsize", HSIZE, e_hsize);
            check("w_hwrite", HWRITE, 1);
            check("w_hprot", HPROT, {2'b00, prot[0], ~prot[2]});
            check("w_hburst", HBURST, 3'b000);
            tick();
            check("w_htrans_data", HTRANS, 2'b00);
            check("w_hsel_data", HSEL, 0);
            check("w_hwdata", HWDATA, data);
            HRESP = err;
            for (int i = 0; i < waits; i++) begin
                HREADY = 1'b0;
                tick();
                check("w_bvalid_wait", BVALID, 0);
                check("w_htrans_wait", HTRANS, 2'b00);
            end
            HREADY = 1'b1;
            tick();
            HRESP = 1'b0;
        end else begin
            check("w_htrans_illegal", HTRANS, 2'b00);
            check("w_hsel_illegal", HSEL, 0);
        end
        collect_b(bstall);
    endtask

    task automatic run_read(input logic [63:0] addr, input logic [2:0] prot, input logic [63:0] e_haddr,
                            input logic [63:0] rdata, input int waits, input int rstall);
        exp_t e;
        ARADDR  = addr;
        ARPROT  = prot;
        ARVALID = 1'b1;
        #1;
        check("arready", ARREADY, 1);
        check("awready_rgrant", AWREADY, 0);
        e.resp = 2'b00;
        e.data = rdata;
        sb.push_back(e);
        tick();
        ARVALID = 1'b0;
        check("r_htrans_addr", HTRANS, 2'b10);
        check("r_hsel_addr", HSEL, 1);
        check("r_haddr", HADDR, e_haddr);
        check("r_hsize", HSIZE, 3'd3);
        check("r_hwrite", HWRITE, 0);
        check("r_hprot", HPROT, {2'b00, prot[0], ~prot[2]});
        tick();
        check("r_htrans_data", HTRANS, 2'b00);
        check("r_hsel_data", HSEL, 0);
        HRDATA = ~rdata;
        for (int i = 0; i < waits; i++) begin
            HREADY = 1'b0;
            tick();
            check("r_rvalid_wait", RVALID, 0);
        end
        HRDATA = rdata;
        HREADY = 1'b1;
        tick();
        HRDATA = ~rdata;
        collect_r(rstall);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        AWADDR  = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA   = '0; WSTRB  = '0; WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = '0; ARPROT = '0; ARVALID = 1'b0;
        RREADY  = 1'b0;
        HRDATA  = '0; HREADY = 1'b1; HRESP = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_awready", AWREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_hsel", HSEL, 0);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_haddr", HADDR, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hsize", HSIZE, 0);
        check("rst_hburst", HBURST, 0);
        check("rst_hprot", HPROT, 4'b0011);
        check("rst_hmastlock", HMASTLOCK, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rresp", RRESP, 0);
        HRESETn = 1'b1;
        tick();

        // Full-width write, zero wait states
        run_write(64'h40, 64'h1122334455667788, 8'hFF, 3'b001, 1'b1, 64'h40, 3'd3, 0, 1'b0, 0);

        // Sub-word writes
        run_write(64'h40, 64'hAAAA_BBBB_CCCC_DDDD, 8'h04, 3'b001, 1'b1, 64'h42, 3'd0, 0, 1'b0, 0);
        run_write(64'h40, 64'h0123_4567_89AB_CDEF, 8'h30, 3'b000, 1'b1, 64'h44, 3'd1, 0, 1'b0, 1);
        run_write(64'h48, 64'hFEDC_BA98_7654_3210, 8'hF0, 3'b101, 1'b1, 64'h4C, 3'd2, 0, 1'b0, 0);
        run_write(64'h40, 64'h5555_6666_7777_8888, 8'h80, 3'b100, 1'b1, 64'h47, 3'd0, 1, 1'b0, 0);

        // Illegal strobes skip the AHB phases
        run_write(64'h40, 64'h1, 8'h05, 3'b001, 1'b0, 64'h0, 3'd0, 0, 1'b0, 0);
        run_write(64'h40, 64'h2, 8'h00, 3'b001, 1'b0, 64'h0, 3'd0, 0, 1'b0, 1);
        run_write(64'h40, 64'h3, 8'h06, 3'b001, 1'b0, 64'h0, 3'd0, 0, 1'b0, 0);
        run_write(64'h40, 64'h4, 8'h0E, 3'b001, 1'b0, 64'h0, 3'd0, 0, 1'b0, 0);

        // Read with data-phase wait states and RREADY back-pressure
        run_read(64'h47, 3'b001, 64'h40, 64'hDEADBEEFCAFEF00D, 2, 3);

        // Contention: write wins after a read, then a re-raised write loses to the waiting read
        ARADDR  = 64'h80;
        ARPROT  = 3'b000;
        ARVALID = 1'b1;
        run_write(64'h88, 64'h0BAD_F00D_1234_5678, 8'hFF, 3'b000, 1'b1, 64'h88, 3'd3, 0, 1'b0, 0);
        AWADDR  = 64'h90;
        AWPROT  = 3'b001;
        WDATA   = 64'h1357_9BDF_2468_ACE0;
        WSTRB   = 8'h0F;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        run_read(64'h80, 3'b000, 64'h80, 64'h0F0F_1E1E_2D2D_3C3C, 0, 0);
        run_write(64'h90, 64'h1357_9BDF_2468_ACE0, 8'h0F, 3'b001, 1'b1, 64'h90, 3'd2, 0, 1'b0, 0);

        // Two-cycle AHB error on a write
        run_write(64'h60, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF, 3'b001, 1'b1, 64'h60, 3'd3, 1, 1'b1, 1);

        // Reset while the write data phase is stalled
        AWADDR  = 64'h100;
        AWPROT  = 3'b001;
        WDATA   = 64'h7777_7777_7777_7777;
        WSTRB   = 8'hFF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        #1;
        check("rst_op_awready", AWREADY, 1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("rst_op_htrans_addr", HTRANS, 2'b10);
        tick();
        HREADY = 1'b0;
        check("rst_op_hwdata", HWDATA, 64'h7777_7777_7777_7777);
        tick();
        HRESETn = 1'b0;
        #1;
        check("rst_op_hsel", HSEL, 0);
        check("rst_op_htrans", HTRANS, 2'b00);
        check("rst_op_haddr", HADDR, 0);
        check("rst_op_hwdata0", HWDATA, 0);
        check("rst_op_hwrite", HWRITE, 0);
        check("rst_op_hprot", HPROT, 4'b0011);
        check("rst_op_bvalid", BVALID, 0);
        tick();
        HREADY = 1'b1;
        tick();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_bvalid", BVALID, 0);
            check("post_rst_htrans", HTRANS, 2'b00);
        end
        run_read(64'h1F8, 3'b100, 64'h1F8, 64'h8899_AABB_CCDD_EEFF, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
